counter_sequencer: RTL and testbench

//   Command-driven controller for a bounded up-counter (4-bit by default).

---
 rtl/counter_sequencer_pkg.sv | 17 +
 rtl/counter_sequencer_if.sv | 26 ++
 rtl/counter_sequencer_core.sv | 19 +
 rtl/counter_sequencer.sv | 93 +++++++++
 tb/tb_counter_sequencer.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/counter_sequencer_pkg.sv
// Shared types for the counter sequencer: FSM state encoding and command opcodes.
package counter_seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  typedef logic [1:0] op_t;

  localparam op_t OP_START  = 2'b00;
  localparam op_t OP_STOP   = 2'b01;
  localparam op_t OP_PAUSE  = 2'b10;
  localparam op_t OP_RESUME = 2'b11;

endpackage

// File: rtl/counter_sequencer_if.sv
// Command and status bundle between host logic and the counter sequencer.
// SEQ_AUTO_RELOAD_EN adds the cfg_reload signal for periodic mode.
interface counter_sequencer_if #(parameter int WIDTH = 4);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [WIDTH-1:0] cmd_limit;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             paused;
  logic             done;
  logic             err;
`ifdef SEQ_AUTO_RELOAD_EN
  logic             cfg_reload;

  modport master (output cmd_valid, cmd_op, cmd_limit, cfg_reload,
                  input  cmd_ready, count, busy, paused, done, err);
  modport slave  (input  cmd_valid, cmd_op, cmd_limit, cfg_reload,
                  output cmd_ready, count, busy, paused, done, err);
`else
  modport master (output cmd_valid, cmd_op, cmd_limit,
                  input  cmd_ready, count, busy, paused, done, err);
  modport slave  (input  cmd_valid, cmd_op, cmd_limit,
                  output cmd_ready, count, busy, paused, done, err);
`endif
endinterface

// File: rtl/counter_sequencer_core.sv
// Counter datapath register: synchronous clear has priority over increment.
module counter_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  // Count register with clear-over-enable priority.
  always_ff @(posedge clk) begin
    if (reset)    q <= '0;
    else if (clr) q <= '0;
    else if (en)  q <= q + WIDTH'(1);
  end

endmodule

// File: rtl/counter_sequencer.sv
// Command-driven sequencer for a bounded up-counter.
// Optional build macro: SEQ_AUTO_RELOAD_EN (periodic reload via cfg_reload).
//
//   state | meaning
//   IDLE  | stopped, count holds last value
//   RUN   | counting toward limit_q
//   PAUSE | count frozen, waiting for RESUME or STOP
module counter_sequencer
  import counter_seq_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                clk,
  input  logic                reset,
  counter_sequencer_if.slave  bus
);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] limit_q;
  logic [WIDTH-1:0] count;
  logic             accept;
  logic             at_limit;
  logic             reload;
  logic             cnt_clr;
  logic             cnt_en;
  logic             illegal;

  assign bus.cmd_ready = 1'b1;
  assign accept        = bus.cmd_valid;
  assign at_limit      = (count == limit_q);

`ifdef SEQ_AUTO_RELOAD_EN
  assign reload = bus.cfg_reload;
`else
  assign reload = 1'b0;
`endif

  // Counter controls: any accepted command freezes the count except START, which clears it.
  assign cnt_clr = (accept && bus.cmd_op == OP_START) ||
                   (!accept && state == RUN && at_limit && reload);
  assign cnt_en  = !accept && state == RUN && !at_limit;

  // Next-state and illegal-command decode.
  always_comb begin
    state_nxt = state;
    illegal   = 1'b0;
    if (accept) begin
      case (bus.cmd_op)
        OP_START:  state_nxt = RUN;
        OP_STOP:   if (state == IDLE) illegal = 1'b1; else state_nxt = IDLE;
        OP_PAUSE:  if (state == RUN) state_nxt = PAUSE; else illegal = 1'b1;
        default:   if (state == PAUSE) state_nxt = RUN; else illegal = 1'b1;
      endcase
    end else if (state == RUN && at_limit && !reload) begin
      state_nxt = IDLE;
    end
  end

  // FSM state, captured limit and registered status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      limit_q    <= '0;
      bus.done   <= 1'b0;
      bus.err    <= 1'b0;
      bus.busy   <= 1'b0;
      bus.paused <= 1'b0;
    end else begin
      state      <= state_nxt;
      bus.busy   <= (state_nxt != IDLE);
      bus.paused <= (state_nxt == PAUSE);
      bus.done   <= !accept && state == RUN && at_limit;
      if (accept && bus.cmd_op == OP_START) begin
        limit_q <= bus.cmd_limit;
        bus.err <= 1'b0;
      end else if (illegal) begin
        bus.err <= 1'b1;
      end
    end
  end

  counter_core #(.WIDTH(WIDTH)) u_core (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .q     (count)
  );

  assign bus.count = count;

endmodule

// File: tb/tb_counter_sequencer.sv
// Self-checking bench for counter_sequencer: fixed vector table, directed
// corner sequences and a randomized run against a behavioural model.
module tb_counter_sequencer;
  import counter_seq_pkg::*;

  localparam int WIDTH = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  counter_sequencer_if #(.WIDTH(WIDTH)) bus ();

  counter_sequencer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model: plain ints and flags derived from the command rules.
  int m_count, m_limit;
  bit m_running, m_paused, m_done, m_err;

  function automatic void model_step(bit rst, bit v, logic [1:0] op, int lim, bit rl);
    bit idle;
    if (rst) begin
      m_count = 0; m_limit = 0; m_running = 0; m_paused = 0; m_done = 0; m_err = 0;
      return;
    end
    idle   = !m_running && !m_paused;
    m_done = 0;
    if (v) begin
      if (op == OP_START) begin
        m_limit = lim; m_count = 0; m_err = 0; m_running = 1; m_paused = 0;
      end else if (op == OP_STOP) begin
        if (idle) m_err = 1;
        else begin m_running = 0; m_paused = 0; end
      end else if (op == OP_PAUSE) begin
        if (m_running) begin m_running = 0; m_paused = 1; end
        else m_err = 1;
      end else begin
        if (m_paused) begin m_paused = 0; m_running = 1; end
        else m_err = 1;
      end
    end else if (m_running) begin
      if (m_count < m_limit) m_count++;
      else begin
        m_done = 1;
        if (rl) m_count = 0;
        else m_running = 0;
      end
    end
  endfunction

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  bit cur_reload = 0;

  // Drive one cycle, advance the model, sample #1 after the edge.
  task automatic cycle(bit rst, bit v, logic [1:0] op, int lim);
    reset         = rst;
    bus.cmd_valid = v;
    bus.cmd_op    = op;
    bus.cmd_limit = WIDTH'(lim);
`ifdef SEQ_AUTO_RELOAD_EN
    bus.cfg_reload = cur_reload;
`endif
    model_step(rst, v, op, lim, cur_reload);
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    cycle(0, 0, OP_STOP, 0);
  endtask

  task automatic check_model(string tag);
    check({tag, ".count"},  int'(bus.count),  m_count);
    check({tag, ".busy"},   int'(bus.busy),   int'(m_running || m_paused));
    check({tag, ".paused"}, int'(bus.paused), int'(m_paused));
    check({tag, ".done"},   int'(bus.done),   int'(m_done));
    check({tag, ".err"},    int'(bus.err),    int'(m_err));
  endtask

  typedef struct {
    bit         v;
    logic [1:0] op;
    int         lim;
    int         count;
    bit         busy;
    bit         paused;
    bit         done;
    bit         err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = OP_START;
    bus.cmd_limit = '0;
`ifdef SEQ_AUTO_RELOAD_EN
    bus.cfg_reload = 1'b0;
`endif

    // Reset state.
    cycle(1, 0, OP_STOP, 0);
    cycle(1, 0, OP_STOP, 0);
    check("reset.count", int'(bus.count), 0);
    check("reset.busy",  int'(bus.busy),  0);
    check("reset.done",  int'(bus.done),  0);
    check("reset.err",   int'(bus.err),   0);
    check("ready",       int'(bus.cmd_ready), 1);

    // Table: one-shot limit 3, illegal RESUME in IDLE, START limit 0.
    vecs.push_back('{1, OP_START,  3, 0, 1, 0, 0, 0});
    vecs.push_back('{0, OP_STOP,   0, 1, 1, 0, 0, 0});
    vecs.push_back('{0, OP_STOP,   0, 2, 1, 0, 0, 0});
    vecs.push_back('{0, OP_STOP,   0, 3, 1, 0, 0, 0});
    vecs.push_back('{0, OP_STOP,   0, 3, 0, 0, 1, 0});
    vecs.push_back('{0, OP_STOP,   0, 3, 0, 0, 0, 0});
    vecs.push_back('{1, OP_RESUME, 0, 3, 0, 0, 0, 1});
    vecs.push_back('{0, OP_STOP,   0, 3, 0, 0, 0, 1});
    vecs.push_back('{1, OP_PAUSE,  9, 3, 0, 0, 0, 1});
    vecs.push_back('{1, OP_START,  0, 0, 1, 0, 0, 0});
    vecs.push_back('{0, OP_STOP,   0, 0, 0, 0, 1, 0});
    vecs.push_back('{1, OP_START,  4, 0, 1, 0, 0, 0});
    vecs.push_back('{1, OP_RESUME, 0, 0, 1, 0, 0, 1});
    vecs.push_back('{0, OP_STOP,   0, 1, 1, 0, 0, 1});
    vecs.push_back('{1, OP_PAUSE,  0, 1, 1, 1, 0, 1});
    vecs.push_back('{1, OP_PAUSE,  0, 1, 1, 1, 0, 1});
    vecs.push_back('{1, OP_STOP,   0, 1, 0, 0, 0, 1});
    foreach (vecs[i]) begin
      cycle(0, vecs[i].v, vecs[i].op, vecs[i].lim);
      check($sformatf("vec%0d.count", i),  int'(bus.count),  vecs[i].count);
      check($sformatf("vec%0d.busy", i),   int'(bus.busy),   int'(vecs[i].busy));
      check($sformatf("vec%0d.paused", i), int'(bus.paused), int'(vecs[i].paused));
      check($sformatf("vec%0d.done", i),   int'(bus.done),   int'(vecs[i].done));
      check($sformatf("vec%0d.err", i),    int'(bus.err),    int'(vecs[i].err));
    end

    // PAUSE at count 2, hold 4 cycles, RESUME to completion.
    cycle(0, 1, OP_START, 5);
    idle_cycle();
    idle_cycle();
    check("pause.pre", int'(bus.count), 2);
    cycle(0, 1, OP_PAUSE, 0);
    for (int i = 0; i < 4; i++) begin
      idle_cycle();
      check("pause.hold_count", int'(bus.count), 2);
      check("pause.paused",     int'(bus.paused), 1);
    end
    cycle(0, 1, OP_RESUME, 0);
    check_model("resume");
    for (int i = 0; i < 4; i++) begin
      idle_cycle();
      check_model("resume_run");
    end
    check("resume.done", int'(bus.done), 1);
    check("resume.count", int'(bus.count), 5);

    // Full-scale limit: no wrap.
    cycle(0, 1, OP_START, 15);
    for (int i = 0; i < 16; i++) idle_cycle();
    check("max.count", int'(bus.count), 15);
    check("max.done",  int'(bus.done),  1);
    idle_cycle();
    check("max.hold",  int'(bus.count), 15);
    check("max.done_pulse", int'(bus.done), 0);

    // STOP on the terminal cycle suppresses done.
    cycle(0, 1, OP_START, 2);
    idle_cycle();
    idle_cycle();
    cycle(0, 1, OP_STOP, 0);
    check("stop_term.done",  int'(bus.done),  0);
    check("stop_term.busy",  int'(bus.busy),  0);
    check("stop_term.count", int'(bus.count), 2);
    idle_cycle();
    check("stop_term.done2", int'(bus.done),  0);

    // PAUSE at limit: done one edge after RESUME.
    cycle(0, 1, OP_START, 1);
    idle_cycle();
    cycle(0, 1, OP_PAUSE, 0);
    cycle(0, 1, OP_RESUME, 0);
    check("plim.resume_done", int'(bus.done), 0);
    idle_cycle();
    check("plim.done", int'(bus.done), 1);
    check("plim.count", int'(bus.count), 1);

    // Reset mid-run.
    cycle(0, 1, OP_START, 7);
    cycle(0, 1, OP_RESUME, 0);
    idle_cycle();
    idle_cycle();
    check("rst_mid.pre", int'(bus.count), 2);
    cycle(1, 0, OP_STOP, 0);
    check("rst_mid.count", int'(bus.count), 0);
    check("rst_mid.busy",  int'(bus.busy),  0);
    check("rst_mid.done",  int'(bus.done),  0);
    check("rst_mid.err",   int'(bus.err),   0);

`ifdef SEQ_AUTO_RELOAD_EN
    // Periodic mode: 0,1,2,0,1,2 with done on each wrap.
    cur_reload = 1;
    cycle(0, 1, OP_START, 2);
    for (int i = 0; i < 8; i++) begin
      idle_cycle();
      check_model("reload");
    end
    cur_reload = 0;
`endif

    // Randomized traffic against the model.
    cycle(1, 0, OP_STOP, 0);
    for (int i = 0; i < 400; i++) begin
`ifdef SEQ_AUTO_RELOAD_EN
      cur_reload = ($urandom_range(0, 3) == 0);
`endif
      if ($urandom_range(0, 99) < 2)
        cycle(1, 0, OP_STOP, 0);
      else
        cycle(0, $urandom_range(0, 99) < 25, 2'($urandom_range(0, 3)),
              int'($urandom_range(0, 7)));
      check_model("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
